// File: rtl/clk_tune_ctrl_if.sv
// clk_tune_ctrl_if -- config/status bundle between the misc Wishbone block,
// the PPS glitch filter and the clock-tune discipline loop.
//   master: drives pps_stb and the cfg_* fields, reads tune/status
//   slave : the discipline loop (clk_tune_ctrl)
// Fields:
//   pps_stb      filtered PPS rising-edge pulse (1 cycle)
//   cfg_en       enable the discipline loop
//   cfg_gain     error right-shift before update (0..7)
//   cfg_man_val  manual tune value
//   cfg_man_stb  load cfg_man_val into tune_val
//   tune_val     PDM tune value (12 bit)
//   tune_oe      PDM output enable
//   stat_state   FSM state
//   stat_locked  loop locked
//   stat_err     last accepted error, signed, saturated to 16 bits
//   stat_upd     one-cycle pulse when the loop updates tune_val
interface clk_tune_ctrl_if;
    logic        pps_stb;
    logic        cfg_en;
    logic [2:0]  cfg_gain;
    logic [11:0] cfg_man_val;
    logic        cfg_man_stb;
    logic [11:0] tune_val;
    logic        tune_oe;
    logic [1:0]  stat_state;
    logic        stat_locked;
    logic [15:0] stat_err;
    logic        stat_upd;

    modport master (
        output pps_stb, cfg_en, cfg_gain, cfg_man_val, cfg_man_stb,
        input  tune_val, tune_oe, stat_state, stat_locked, stat_err, stat_upd
    );

    modport slave (
        input  pps_stb, cfg_en, cfg_gain, cfg_man_val, cfg_man_stb,
        output tune_val, tune_oe, stat_state, stat_locked, stat_err, stat_upd
    );
endinterface

// File: rtl/clk_tune_ctrl.sv
// clk_tune_ctrl -- GPS discipline loop for the 12-bit clock-tune PDM.
// Counts clk cycles between filtered PPS pulses, compares the period with
// TARGET and steps tune_val by the arithmetically shifted, clamped error.
// Reports lock / holdover state.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  clk_tune_ctrl_if.slave (pps_stb, cfg_*, tune_*, stat_*)
// Build option:
//   CLK_TUNE_AVG_EN  average 4 accepted errors per tune update
module clk_tune_ctrl #(
    parameter int unsigned TARGET      = 30720000,
    parameter int unsigned W           = 32,
    parameter int unsigned ERR_LIM     = 4096,
    parameter int unsigned LOCK_TOL    = 2,
    parameter int unsigned PPS_TIMEOUT = 34000000
) (
    input  logic           clk,
    input  logic           rst,
    clk_tune_ctrl_if.slave bus
);
    localparam int unsigned SW = W + 4;
    localparam logic signed [W:0]    TARGET_S   = (W+1)'(TARGET);
    localparam logic [W:0]           ERR_LIM_V  = (W+1)'(ERR_LIM);
    localparam logic [W:0]           LOCK_TOL_V = (W+1)'(LOCK_TOL);
    localparam logic [W-1:0]         TIMEOUT_V  = W'(PPS_TIMEOUT);
    localparam logic signed [SW-1:0] TUNE_MAX   = SW'(4095);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACQUIRE  = 2'd1,
        TRACK    = 2'd2,
        HOLDOVER = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [W-1:0]         cnt;
    logic signed [W:0]    err;
    logic                 s1_vld;
    logic [1:0]           rej_cnt;
    logic [2:0]           lock_cnt;
    logic [11:0]          tune_val;
    logic                 tune_oe;
    logic [15:0]          stat_err;
    logic                 stat_upd;

    logic                 cnt_sat;
    logic                 meas;
    logic                 s2;
    logic [W:0]           err_abs;
    logic                 accept;
    logic                 reject;
    logic                 in_lock;
    logic                 err_fits;
    logic [15:0]          err_sat;
    logic                 upd_go;
    logic signed [SW-1:0] step;
    logic signed [SW-1:0] diff;
    logic [11:0]          tune_upd;

    assign cnt_sat = (cnt == TIMEOUT_V);
    assign meas    = (state == TRACK) && bus.pps_stb && bus.cfg_en;
    // A coinciding manual load wins over the stage-2 result.
    assign s2      = s1_vld && bus.cfg_en && !bus.cfg_man_stb;
    assign err_abs = err[W] ? (W+1)'(-err) : (W+1)'(err);
    assign accept  = s2 && (err_abs <= ERR_LIM_V);
    assign reject  = s2 && (err_abs > ERR_LIM_V);
    assign in_lock = (err_abs <= LOCK_TOL_V);

    assign err_fits = (err[W:15] == '0) || (err[W:15] == '1);
    assign err_sat  = err_fits ? err[15:0] : (err[W] ? 16'h8000 : 16'h7fff);

`ifdef CLK_TUNE_AVG_EN
    logic signed [W+2:0] sum;
    logic signed [W+2:0] sum_nxt;
    logic [1:0]          acc_cnt;

    assign sum_nxt = sum + (W+3)'(err);
    assign upd_go  = accept && (acc_cnt == 2'd3);
    assign step    = SW'(sum_nxt) >>> ({2'b00, bus.cfg_gain} + 5'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum     <= '0;
            acc_cnt <= '0;
        end else if (state_nxt != TRACK) begin
            sum     <= '0;
            acc_cnt <= '0;
        end else if (accept) begin
            sum     <= (acc_cnt == 2'd3) ? '0 : sum_nxt;
            acc_cnt <= acc_cnt + 2'd1;
        end
    end
`else
    assign upd_go = accept;
    assign step   = SW'(err) >>> bus.cfg_gain;
`endif

    assign diff = SW'($signed({1'b0, tune_val})) - step;

    always_comb begin
        tune_upd = diff[11:0];
        if (diff[SW-1]) begin
            tune_upd = '0;
        end else if (diff > TUNE_MAX) begin
            tune_upd = '1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!bus.cfg_en) begin
            state_nxt = DISABLED;
        end else begin
            case (state)
                DISABLED: state_nxt = ACQUIRE;
                ACQUIRE:  if (bus.pps_stb) state_nxt = TRACK;
                TRACK: begin
                    if (reject && (rej_cnt == 2'd2)) begin
                        state_nxt = ACQUIRE;
                    end else if (cnt_sat && !bus.pps_stb) begin
                        state_nxt = HOLDOVER;
                    end
                end
                HOLDOVER: if (bus.pps_stb) state_nxt = TRACK;
                default:  state_nxt = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DISABLED;
            cnt      <= '0;
            err      <= '0;
            s1_vld   <= 1'b0;
            rej_cnt  <= '0;
            lock_cnt <= '0;
            tune_val <= '0;
            tune_oe  <= 1'b0;
            stat_err <= '0;
            stat_upd <= 1'b0;
        end else begin
            state    <= state_nxt;
            stat_upd <= 1'b0;

            if (bus.pps_stb) begin
                cnt <= W'(1);
            end else if (!cnt_sat) begin
                cnt <= cnt + W'(1);
            end

            s1_vld <= meas;
            if (meas) begin
                err <= $signed({1'b0, cnt}) - TARGET_S;
            end

            if (bus.cfg_man_stb || ((state_nxt == ACQUIRE) && (state != ACQUIRE))) begin
                tune_oe <= 1'b1;
            end

            if (bus.cfg_man_stb) begin
                tune_val <= bus.cfg_man_val;
            end else if (upd_go) begin
                tune_val <= tune_upd;
                stat_upd <= 1'b1;
            end

            if (accept) begin
                stat_err <= err_sat;
                rej_cnt  <= '0;
                if (!in_lock) begin
                    lock_cnt <= '0;
                end else if (lock_cnt != 3'd4) begin
                    lock_cnt <= lock_cnt + 3'd1;
                end
            end else if (reject) begin
                rej_cnt <= rej_cnt + 2'd1;
            end

            if (state_nxt != TRACK) begin
                rej_cnt  <= '0;
                lock_cnt <= '0;
            end
        end
    end

    assign bus.tune_val    = tune_val;
    assign bus.tune_oe     = tune_oe;
    assign bus.stat_state  = state;
    assign bus.stat_locked = (lock_cnt == 3'd4);
    assign bus.stat_err    = stat_err;
    assign bus.stat_upd    = stat_upd;
endmodule

// File: doc/clk_tune_ctrl.md
Name: clk_tune_ctrl

Overview:
Hardware GPS-discipline loop for the 12-bit clock-tune PDM. Measures system-clock cycles between filtered GPS PPS pulses and compares the period against a nominal count. Steps the tune value by a shifted, saturated error and reports lock and holdover status. Sits between the PPS glitch filter and the clock-tune PDM core; its config and status registers are exposed on the misc Wishbone block.

Parameters:
TARGET, 30720000, nominal clk cycles per PPS period
W, 32, period counter width
ERR_LIM, 4096, max |error| accepted; larger measurements are discarded
LOCK_TOL, 2, |error| bound counted as "in lock"
PPS_TIMEOUT, 34000000, cycles without PPS before entering holdover (> TARGET+ERR_LIM)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
pps_stb  in  1  single-cycle pulse on filtered PPS rising edge
cfg_en  in  1  enable the discipline loop
cfg_gain  in  3  right-shift applied to error before update (0..7)
cfg_man_val  in  12  manual tune value
cfg_man_stb  in  1  load cfg_man_val into tune_val
tune_val  out  12  PDM tune value
tune_oe  out  1  PDM output enable
stat_state  out  2  FSM state
stat_locked  out  1  loop locked
stat_err  out  16  last accepted error, signed, saturated to 16 bits
stat_upd  out  1  one-cycle pulse when tune_val is updated by the loop

Behaviour:
- Reset values: tune_val=0, tune_oe=0, stat_state=DISABLED, stat_locked=0, stat_err=0, stat_upd=0, period counter=0, reject count=0, lock count=0.
- FSM states: DISABLED=0, ACQUIRE=1, TRACK=2, HOLDOVER=3.
- cfg_en=0, in any state: go to DISABLED on the next cycle, tune_val held, locked cleared, any in-flight update dropped.
- DISABLED to ACQUIRE: cfg_en=1. Entering ACQUIRE sets tune_oe=1. cfg_man_stb also sets tune_oe=1, in any state.
- ACQUIRE to TRACK: on pps_stb. Restarts the counter; no update.
- Counter: on pps_stb, sample P=cnt, then cnt<=1. Otherwise cnt increments, saturating at PPS_TIMEOUT. P therefore equals the number of cycles between two pulses.
- TRACK, on each pps_stb:
  - Stage 1 (t+1): register E = P - TARGET, signed W+1 bits.
  - Stage 2 (t+2), if |E| <= ERR_LIM:
    - tune_val <= clamp(tune_val - (E >>> cfg_gain), 0, 4095). The shift is arithmetic and rounds toward minus infinity.
    - stat_err <= sat16(E); stat_upd=1 for one cycle; reject count cleared.
  - Stage 2, if |E| > ERR_LIM: no update, no stat_upd, reject count +1. On the 3rd consecutive reject, go to ACQUIRE.
- Lock: lock count increments on each accepted |E| <= LOCK_TOL; any larger accepted error clears it. stat_locked=1 once the count reaches 4. Locked and lock count are cleared on leaving TRACK.
- TRACK to HOLDOVER: cnt reaches PPS_TIMEOUT. tune_val is frozen and locked cleared.
- HOLDOVER to TRACK: on pps_stb. Counter restarts; that pulse produces no update.
- cfg_man_stb: tune_val <= cfg_man_val on the next cycle, in any state. If it coincides with a pending stage-2 update, the manual load wins, the measurement is dropped and no stat_upd is issued. The counter still restarts on the PPS.
- pps_stb during stage 1 or 2 of a prior pulse starts a new measurement. Its short period is rejected by ERR_LIM.

Optional Feature:
Macro CLK_TUNE_AVG_EN.
- Defined: accepted errors accumulate in a signed (W+3)-bit sum. Every 4th accepted error applies tune_val - (sum >>> (cfg_gain+2)), clears the sum and pulses stat_upd. stat_err still reports each accepted E. The sum is cleared whenever the FSM leaves TRACK.
- Undefined: every accepted measurement updates tune_val directly. No accumulator logic is built.

Test Plan:
All cases use TARGET=1000, ERR_LIM=100, LOCK_TOL=2, PPS_TIMEOUT=1200, macro undefined.
- Man load 2048, cfg_en=1, PPS at 0 then every 1000 cycles -> tune_val stays 2048, stat_err=0, stat_upd each PPS at t+2, stat_locked=1 after the 4th accepted period.
- Locked, period 1016, gain=2 -> E=16, tune_val 2044 at t+2, stat_locked=0. Period 990, gain=0 -> E=-10, tune_val 2054.
- tune_val 4090, period 980, gain=0 -> clamps to 4095. Man load 3, period 1010 -> clamps to 0.
- Three periods of 1150 -> no stat_upd, tune unchanged; stat_state=1 after the third. Next PPS -> state 2, no update.
- No PPS for 1200 cycles in TRACK -> state 3, tune frozen, locked=0. Next PPS -> state 2, no stat_upd. Following 1000-cycle period -> update.
- cfg_man_stb=1 with cfg_man_val=100 at t+1 after PPS of period 1010 -> tune_val=100, no stat_upd. Next 1000-cycle period -> accepted with E=0.
